// File: rtl/snoop_responder_if.sv
// Snoop-bus bundle between a requesting cache controller / memory side
// (master) and the remote-cache snoop responder (slave).
//   snoop_*     : snoop request and response handshake
//   mem_*       : writeback port towards memory
//   fill_*      : local line-install port
//   local_*     : combinational state lookup for the local controller
//   hit_cnt/wb_cnt : statistics counters (zero unless SNOOP_STATS_EN)
interface snoop_responder_if #(
  parameter int ADDR_W = 8
);
  logic              snoop_in;
  logic [1:0]        snoop_func;
  logic [ADDR_W-1:0] snoop_addr;
  logic              snoop_hit;
  logic              snoop_ready;
  logic              mem_wr;
  logic              mem_cs;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [1:0]        fill_stat;
  logic              fill_ready;
  logic [ADDR_W-1:0] local_addr;
  logic [1:0]        local_stat;
  logic [15:0]       hit_cnt;
  logic [15:0]       wb_cnt;

  modport master (
    output snoop_in, snoop_func, snoop_addr, mem_ready,
           fill_valid, fill_addr, fill_stat, local_addr,
    input  snoop_hit, snoop_ready, mem_wr, mem_cs, mem_addr,
           fill_ready, local_stat, hit_cnt, wb_cnt
  );

  modport slave (
    input  snoop_in, snoop_func, snoop_addr, mem_ready,
           fill_valid, fill_addr, fill_stat, local_addr,
    output snoop_hit, snoop_ready, mem_wr, mem_cs, mem_addr,
           fill_ready, local_stat, hit_cnt, wb_cnt
  );
endinterface

// File: rtl/snoop_responder.sv
// snoop_responder: remote-cache side of an MSI snoop bus.
// Answers GetS (b_read, 2'b10) and GetX (p_write, 2'b01) snoops from a
// direct-mapped tag/state array. Dirty (excl) lines are written back to
// memory before the response, then downgraded to shrd (GetS) or
// invalidated (GetX). The array is also exported to the local controller.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : snoop_responder_if.slave (snoop, writeback, fill, local lookup,
//           statistics)
// Optional feature macro: SNOOP_STATS_EN builds saturating 16-bit hit and
// writeback counters; without it hit_cnt/wb_cnt are constant zero.
module snoop_responder #(
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  snoop_responder_if.slave  bus
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  localparam logic [1:0] STAT_INVL = 2'b00;
  localparam logic [1:0] STAT_SHRD = 2'b10;
  localparam logic [1:0] STAT_EXCL = 2'b11;
  localparam logic [1:0] FUNC_GETX = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_RESP, S_WAIT_LOW
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              getx_q, getx_d;
  logic              hit_q, hit_d;

  logic [TAG_W-1:0]   tag_rd  [LINES];
  logic [1:0]         stat_rd [LINES];

  logic [INDEX_W-1:0] snoop_idx, fill_idx, local_idx;
  logic [TAG_W-1:0]   snoop_tag, fill_tag, local_tag;
  logic               lookup_hit, lookup_excl, fill_fire, resp_update;

  assign snoop_idx = addr_q[INDEX_W-1:0];
  assign snoop_tag = addr_q[ADDR_W-1:INDEX_W];
  assign fill_idx  = bus.fill_addr[INDEX_W-1:0];
  assign fill_tag  = bus.fill_addr[ADDR_W-1:INDEX_W];
  assign local_idx = bus.local_addr[INDEX_W-1:0];
  assign local_tag = bus.local_addr[ADDR_W-1:INDEX_W];

  assign lookup_hit  = (tag_rd[snoop_idx] == snoop_tag) && (stat_rd[snoop_idx] != STAT_INVL);
  assign lookup_excl = (stat_rd[snoop_idx] == STAT_EXCL);
  // A snoop always wins over a same-cycle fill; the fill is simply refused.
  assign fill_fire   = (state_q == S_IDLE) && !bus.snoop_in && bus.fill_valid;
  assign resp_update = (state_q == S_RESP) && hit_q;

  // One tag/state entry per line. Fills and snoop downgrades never collide
  // because they happen in different FSM states.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line
      logic [TAG_W-1:0] tag_q, tag_d;
      logic [1:0]       stat_q, stat_d;

      always_comb begin
        tag_d  = tag_q;
        stat_d = stat_q;
        if (fill_fire && (fill_idx == INDEX_W'(gi))) begin
          tag_d  = fill_tag;
          stat_d = bus.fill_stat;
        end else if (resp_update && (snoop_idx == INDEX_W'(gi))) begin
          // GetS leaves the line shared (excl was already written back);
          // GetX takes ownership away entirely.
          stat_d = getx_q ? STAT_INVL : STAT_SHRD;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          tag_q  <= '0;
          stat_q <= STAT_INVL;
        end else begin
          tag_q  <= tag_d;
          stat_q <= stat_d;
        end
      end

      assign tag_rd[gi]  = tag_q;
      assign stat_rd[gi] = stat_q;
    end
  endgenerate

  // State register and snoop context
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      getx_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      getx_q  <= getx_d;
      hit_q   <= hit_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.snoop_in) state_d = S_LOOKUP;
      S_LOOKUP:   state_d = (lookup_hit && lookup_excl) ? S_WB : S_RESP;
      S_WB:       if (bus.mem_ready) state_d = S_RESP;
      S_RESP:     state_d = S_WAIT_LOW;
      // Wait for the requester to drop its request so it is answered once.
      S_WAIT_LOW: if (!bus.snoop_in) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Snoop context capture
  always_comb begin
    addr_d = addr_q;
    getx_d = getx_q;
    hit_d  = hit_q;
    case (state_q)
      S_IDLE: begin
        if (bus.snoop_in) begin
          addr_d = bus.snoop_addr;
          getx_d = (bus.snoop_func == FUNC_GETX);
        end
      end
      S_LOOKUP: hit_d = lookup_hit;
      S_RESP:   hit_d = 1'b0;
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.snoop_ready = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_cs      = 1'b0;
    bus.mem_addr    = '0;
    case (state_q)
      S_WB: begin
        bus.mem_wr   = 1'b1;
        bus.mem_cs   = 1'b1;
        bus.mem_addr = addr_q;
      end
      S_RESP:  bus.snoop_ready = 1'b1;
      default: ;
    endcase
    // hit_q is only ever set between LOOKUP and RESP
    bus.snoop_hit  = hit_q;
    bus.fill_ready = fill_fire;
    bus.local_stat = (tag_rd[local_idx] == local_tag) ? stat_rd[local_idx] : STAT_INVL;
  end

`ifdef SNOOP_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] wb_cnt_q, wb_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    wb_cnt_d  = wb_cnt_q;
    if (resp_update && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
    if ((state_q == S_WB) && bus.mem_ready && (wb_cnt_q != 16'hFFFF)) wb_cnt_d = wb_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q <= '0;
      wb_cnt_q  <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      wb_cnt_q  <= wb_cnt_d;
    end
  end

  assign bus.hit_cnt = hit_cnt_q;
  assign bus.wb_cnt  = wb_cnt_q;
`else
  assign bus.hit_cnt = '0;
  assign bus.wb_cnt  = '0;
`endif
endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: snoop responses are checked
// against a scoreboard of expected hit/latency entries pushed at issue time.
module tb_snoop_responder;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  snoop_responder_if #(.ADDR_W(ADDR_W)) bus ();

  snoop_responder #(.ADDR_W(ADDR_W), .INDEX_W(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic       hit;
    int         lat;
    logic [7:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   exp_hits = 0;
  int   exp_wbs  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_local(input logic [7:0] addr, input logic [1:0] exp);
    bus.local_addr = addr;
    @(negedge clk);
    check("local_stat", bus.local_stat, exp);
  endtask

  task automatic check_counters();
`ifdef SNOOP_STATS_EN
    check("hit_cnt", bus.hit_cnt, exp_hits);
    check("wb_cnt", bus.wb_cnt, exp_wbs);
`else
    check("hit_cnt", bus.hit_cnt, 0);
    check("wb_cnt", bus.wb_cnt, 0);
`endif
  endtask

  task automatic do_fill(input logic [7:0] addr, input logic [1:0] stat);
    @(posedge clk); #1;
    bus.fill_valid = 1'b1;
    bus.fill_addr  = addr;
    bus.fill_stat  = stat;
    @(negedge clk);
    check("fill_ready", bus.fill_ready, 1);
    $display("fill addr=%h stat=%b fill_ready=%b", addr, stat, bus.fill_ready);
    @(posedge clk); #1;
    bus.fill_valid = 1'b0;
  endtask

  // Issue one snoop; wb_wait = number of WB cycles expected (0 = clean),
  // hold = extra cycles snoop_in stays high after snoop_ready.
  task automatic do_snoop(input logic [1:0] func, input logic [7:0] addr,
                          input logic exp_hit, input int wb_wait, input int hold,
                          input bit with_fill);
    exp_t e, x;
    int   cyc, readies, wbc;
    bit   done;
    e.hit  = exp_hit;
    e.lat  = (wb_wait > 0) ? 2 + wb_wait : 2;
    e.addr = addr;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.snoop_in   = 1'b1;
    bus.snoop_func = func;
    bus.snoop_addr = addr;
    if (with_fill) bus.fill_valid = 1'b1;
    @(negedge clk);
    check("fill_ready_conflict", bus.fill_ready, 0);
    @(posedge clk);
    cyc = 0; readies = 0; wbc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      check("fill_ready_busy", bus.fill_ready, 0);
      if (cyc == 1) check("hit_in_lookup", bus.snoop_hit, 0);
      if (bus.mem_wr || bus.mem_cs) begin
        wbc++;
        check("mem_cs_wb", bus.mem_cs, 1);
        check("mem_addr", bus.mem_addr, addr);
        check("hit_in_wb", bus.snoop_hit, 1);
        bus.mem_ready = (wbc == wb_wait);
      end else begin
        bus.mem_ready = 1'b0;
      end
      if (bus.snoop_ready) begin
        x = sb_q.pop_front();
        readies++;
        check("snoop_hit", bus.snoop_hit, x.hit);
        check("latency", cyc, x.lat);
        $display("snoop func=%b addr=%h hit=%b latency=%0d wb_cycles=%0d",
                 func, x.addr, bus.snoop_hit, cyc, wbc);
        done = 1;
      end
    end
    if (!done) check("ready_timeout", 0, 1);
    bus.mem_ready = 1'b0;
    check("wb_cycles", wbc, wb_wait);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.snoop_ready) readies++;
      check("hit_cleared", bus.snoop_hit, 0);
      check("fill_ready_wait", bus.fill_ready, 0);
    end
    check("ready_count", readies, 1);
    @(posedge clk); #1;
    bus.snoop_in = 1'b0;
    @(posedge clk); #1;
    if (exp_hit) exp_hits++;
    if (wb_wait > 0) exp_wbs++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset          = 1'b1;
    bus.snoop_in   = 1'b0;
    bus.snoop_func = 2'b00;
    bus.snoop_addr = '0;
    bus.mem_ready  = 1'b0;
    bus.fill_valid = 1'b0;
    bus.fill_addr  = '0;
    bus.fill_stat  = 2'b00;
    bus.local_addr = 8'h2A;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_snoop_ready", bus.snoop_ready, 0);
    check("rst_snoop_hit", bus.snoop_hit, 0);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_mem_cs", bus.mem_cs, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_fill_ready", bus.fill_ready, 0);
    check("rst_local_stat", bus.local_stat, 0);
    check_counters();
    @(posedge clk); #1;
    reset = 1'b0;

    // GetS miss on empty array
    do_snoop(2'b10, 8'h2A, 1'b0, 0, 0, 1'b0);
    check_local(8'h2A, 2'b00);

    // GetS on shared line
    do_fill(8'h2A, 2'b10);
    check_local(8'h2A, 2'b10);
    do_snoop(2'b10, 8'h2A, 1'b1, 0, 0, 1'b0);
    check_local(8'h2A, 2'b10);

    // GetS on exclusive line: 3-cycle writeback then downgrade
    do_fill(8'h2A, 2'b11);
    check_local(8'h2A, 2'b11);
    do_snoop(2'b10, 8'h2A, 1'b1, 3, 0, 1'b0);
    check_local(8'h2A, 2'b10);
    check_counters();

    // GetX on shared line: no writeback, invalidate
    do_fill(8'h15, 2'b10);
    do_snoop(2'b01, 8'h15, 1'b1, 0, 0, 1'b0);
    check_local(8'h15, 2'b00);

    // Fill overwrites same index with a new tag; old address now misses
    do_fill(8'h6A, 2'b11);
    check_local(8'h2A, 2'b00);
    do_snoop(2'b10, 8'h2A, 1'b0, 0, 0, 1'b0);
    // GetX on exclusive line: 1-cycle writeback then invalidate
    do_snoop(2'b01, 8'h6A, 1'b1, 1, 0, 1'b0);
    check_local(8'h6A, 2'b00);

    // Undefined func code behaves as GetS
    do_fill(8'h33, 2'b10);
    do_snoop(2'b11, 8'h33, 1'b1, 0, 0, 1'b0);
    check_local(8'h33, 2'b10);

    // Held request plus conflicting fill: one response, fill after WAIT_LOW
    bus.fill_addr = 8'h40;
    bus.fill_stat = 2'b10;
    do_snoop(2'b10, 8'h40, 1'b0, 0, 5, 1'b1);
    @(negedge clk);
    check("fill_after_wait", bus.fill_ready, 1);
    @(posedge clk); #1;
    bus.fill_valid = 1'b0;
    check_local(8'h40, 2'b10);
    check_counters();
    check("scoreboard_empty", sb_q.size(), 0);

    // Reset in the middle of a writeback
    do_fill(8'h2A, 2'b11);
    @(posedge clk); #1;
    bus.snoop_in   = 1'b1;
    bus.snoop_func = 2'b01;
    bus.snoop_addr = 8'h2A;
    bus.local_addr = 8'h2A;
    n = 0;
    while (!bus.mem_wr && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wb_reached", bus.mem_wr, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_wb_mem_wr", bus.mem_wr, 0);
    check("rst_wb_mem_cs", bus.mem_cs, 0);
    check("rst_wb_ready", bus.snoop_ready, 0);
    check("rst_wb_hit", bus.snoop_hit, 0);
    check("rst_wb_local", bus.local_stat, 0);
    $display("reset during writeback: mem_wr=%b local_stat=%b", bus.mem_wr, bus.local_stat);
    bus.snoop_in = 1'b0;
    exp_hits = 0;
    exp_wbs  = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_counters();

    // Clean operation after reset
    do_snoop(2'b10, 8'h2A, 1'b0, 0, 0, 1'b0);
    check_counters();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
